adder_8b: RTL and testbench
===========================

Name: adder_8b

Overview:
- 8-bit binary adder with carry-in and carry-out; result registered, one-cycle latency.
- Core is a ripple-carry chain of eight 1-bit full adders: sum = a^b^c, carry = ab | c(a^b).
- Used as the datapath arithmetic primitive wherever an 8-bit sum plus carry is needed.

Parameters:
- None. Width is fixed at 8 bits.

Ports:
- clk      input   1  system clock; all state updates on rising edge
- rst_n    input   1  asynchronous reset, active low
- in_valid input   1  operands valid this cycle; capture enable
- A        input   8  operand A, unsigned or two's complement
- B        input   8  operand B
- Cin      input   1  carry into bit 0
- S        output  8  registered sum bits [7:0]
- Cout     output  1  registered carry out of bit 7
- out_valid output 1  S/Cout hold the result of the operands captured on the previous edge

Behaviour:
- Reset: rst_n=0 forces S=8'h00, Cout=0 and out_valid=0 immediately, independent of clk. These values hold while rst_n=0.
- Combinational core: {c8, sum[7:0]} = A + B + Cin, a full 9-bit result. Carry ripples through bits 0→7, and c8 is the carry out of bit 7.
- Rising clk edge with in_valid=1: S<=sum, Cout<=c8, out_valid<=1.
- Rising clk edge with in_valid=0: S and Cout hold their previous values, and out_valid<=0.
- Latency: exactly 1 cycle from in_valid sample to out_valid. Throughput is one operation per cycle. Back-to-back in_valid produces a result every cycle.
- No back-pressure. The consumer must take the result in the cycle out_valid=1.
- Wrap-around: the sum is taken modulo 256, with overflow reported only via Cout. For example, FF+01+0 gives S=00, Cout=1, and FF+FF+1 gives S=FF, Cout=1.
- Inputs with X/Z are not sanitized. Outputs are defined only for known inputs.
- Reset asserted mid-stream: the in-flight result is discarded. After rst_n deasserts, the first valid capture occurs on the first rising edge with in_valid=1.
- No combinational path from inputs to outputs.

Optional Feature:
- Macro ADDER_8B_FLAGS_EN.
- When defined, two extra registered outputs are added, loaded under the same in_valid rule as S/Cout and reset to 0:
  - Ovf (1 bit): two's-complement overflow, equal to carry into bit 7 XOR carry out of bit 7. It is 1 when A[7]==B[7] and sum[7]!=A[7].
  - Zero (1 bit): 1 when sum[7:0]==8'h00, regardless of Cout.
- When not defined, these ports and their logic are absent. S, Cout and out_valid behave identically in both builds.

Test Plan:
- Reset: rst_n=0 asynchronously between clock edges → S=00, Cout=0, out_valid=0 immediately, with no clk edge needed. Release, then hold in_valid=0 for 2 cycles → outputs remain 0.
- A=0A, B=05, Cin=0, in_valid=1 → next edge S=0F, Cout=0, out_valid=1 (flags build: Ovf=0, Zero=0).
- A=7F, B=01, Cin=0 → S=80, Cout=0 (flags build: Ovf=1, Zero=0).
- A=C8, B=64, Cin=1 → S=2D, Cout=1 (flags build: Ovf=0).
- A=FF, B=01, Cin=0 → S=00, Cout=1 (flags build: Zero=1, Ovf=0). Then drop in_valid → S/Cout hold 00/1 and out_valid=0.
- Back-to-back stream of the four vectors above with in_valid held high, then rst_n pulsed low mid-stream → each result appears exactly one cycle after its operands. The reset pulse clears outputs at once, and the stream resumes correctly after release.

Source files
------------

// File: rtl/adder_8b.sv
// 8-bit ripple-carry adder with carry-in/out and a registered result (one-cycle latency).
// Define ADDER_8B_FLAGS_EN to add registered two's-complement overflow (Ovf) and zero (Zero) flags.
module adder_8b (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    input  logic [7:0] A,
    input  logic [7:0] B,
    input  logic       Cin,
    output logic [7:0] S,
    output logic       Cout,
`ifdef ADDER_8B_FLAGS_EN
    output logic       Ovf,
    output logic       Zero,
`endif
    output logic       out_valid
);

    localparam int unsigned WIDTH = 8;

    logic [WIDTH-1:0] w_sum;
    logic [WIDTH:0]   w_carry;

    logic [WIDTH-1:0] r_sum;
    logic             r_cout;
    logic             r_valid;

    assign w_carry[0] = Cin;

    // Ripple chain: carry out of bit i feeds bit i+1.
    for (genvar i = 0; i < WIDTH; i++) begin : g_fa
        logic w_p;
        assign w_p          = A[i] ^ B[i];
        assign w_sum[i]     = w_p ^ w_carry[i];
        assign w_carry[i+1] = (A[i] & B[i]) | (w_carry[i] & w_p);
    end

    // Result and carry hold when in_valid is low; out_valid tracks the previous in_valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sum   <= '0;
            r_cout  <= 1'b0;
            r_valid <= 1'b0;
        end else begin
            r_valid <= in_valid;
            if (in_valid) begin
                r_sum  <= w_sum;
                r_cout <= w_carry[WIDTH];
            end
        end
    end

    assign S         = r_sum;
    assign Cout      = r_cout;
    assign out_valid = r_valid;

`ifdef ADDER_8B_FLAGS_EN
    logic w_ovf;
    logic w_zero;
    logic r_ovf;
    logic r_zero;

    // Signed overflow: carry into the sign bit differs from carry out of it.
    assign w_ovf  = w_carry[WIDTH-1] ^ w_carry[WIDTH];
    assign w_zero = ~|w_sum;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ovf  <= 1'b0;
            r_zero <= 1'b0;
        end else if (in_valid) begin
            r_ovf  <= w_ovf;
            r_zero <= w_zero;
        end
    end

    assign Ovf  = r_ovf;
    assign Zero = r_zero;
`endif

endmodule

// File: tb/tb_adder_8b.sv
// Directed-vector bench for adder_8b; expected results are hand-computed constants.
// Flag checks are compiled in when ADDER_8B_FLAGS_EN is defined.
module tb_adder_8b;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic [7:0] A;
    logic [7:0] B;
    logic       Cin;
    logic [7:0] S;
    logic       Cout;
    logic       out_valid;
`ifdef ADDER_8B_FLAGS_EN
    logic       Ovf;
    logic       Zero;
`endif

    int compared;
    int mismatched;

    adder_8b dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .A        (A),
        .B        (B),
        .Cin      (Cin),
        .S        (S),
        .Cout     (Cout),
`ifdef ADDER_8B_FLAGS_EN
        .Ovf      (Ovf),
        .Zero     (Zero),
`endif
        .out_valid(out_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hand-computed vector table: A, B, Cin -> S, Cout, Ovf, Zero.
    localparam int NV = 5;
    logic [7:0] va   [NV] = '{8'h0A, 8'h7F, 8'hC8, 8'hFF, 8'hFF};
    logic [7:0] vb   [NV] = '{8'h05, 8'h01, 8'h64, 8'h01, 8'hFF};
    logic       vc   [NV] = '{1'b0,  1'b0,  1'b1,  1'b0,  1'b1};
    logic [7:0] vs   [NV] = '{8'h0F, 8'h80, 8'h2D, 8'h00, 8'hFF};
    logic       vco  [NV] = '{1'b0,  1'b0,  1'b1,  1'b1,  1'b1};
    logic       vovf [NV] = '{1'b0,  1'b1,  1'b0,  1'b0,  1'b0};
    logic       vz   [NV] = '{1'b0,  1'b0,  1'b0,  1'b1,  1'b0};

    task automatic test_reset;
        rst_n = 1'b1; in_valid = 1'b1; A = 8'h0A; B = 8'h05; Cin = 1'b0;
        @(posedge clk); #1;
        #2 rst_n = 1'b0;
        #1;
        compared++;
        if (S !== 8'h00 || Cout !== 1'b0 || out_valid !== 1'b0) begin
            mismatched++;
            $display("FAIL reset_async: S=%h Cout=%b ov=%b required 00/0/0", S, Cout, out_valid);
        end
`ifdef ADDER_8B_FLAGS_EN
        compared++;
        if (Ovf !== 1'b0 || Zero !== 1'b0) begin
            mismatched++;
            $display("FAIL reset_flags: Ovf=%b Zero=%b required 0/0", Ovf, Zero);
        end
`endif
        @(negedge clk); in_valid = 1'b0; rst_n = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            compared++;
            if (S !== 8'h00 || Cout !== 1'b0 || out_valid !== 1'b0) begin
                mismatched++;
                $display("FAIL reset_idle%0d: S=%h Cout=%b ov=%b required 00/0/0", i, S, Cout, out_valid);
            end
        end
    endtask

    task automatic test_single;
        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            in_valid = 1'b1; A = va[i]; B = vb[i]; Cin = vc[i];
            @(posedge clk); #1;
            compared++;
            if (S !== vs[i] || Cout !== vco[i] || out_valid !== 1'b1) begin
                mismatched++;
                $display("FAIL single%0d: S=%h Cout=%b ov=%b required %h/%b/1", i, S, Cout, out_valid, vs[i], vco[i]);
            end
`ifdef ADDER_8B_FLAGS_EN
            compared++;
            if (Ovf !== vovf[i] || Zero !== vz[i]) begin
                mismatched++;
                $display("FAIL single_flags%0d: Ovf=%b Zero=%b required %b/%b", i, Ovf, Zero, vovf[i], vz[i]);
            end
`endif
            @(negedge clk); in_valid = 1'b0;
            @(posedge clk); #1;
            compared++;
            if (out_valid !== 1'b0 || S !== vs[i] || Cout !== vco[i]) begin
                mismatched++;
                $display("FAIL hold%0d: S=%h Cout=%b ov=%b required %h/%b/0", i, S, Cout, out_valid, vs[i], vco[i]);
            end
        end
    endtask

    task automatic test_back_to_back;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            in_valid = 1'b1; A = va[i]; B = vb[i]; Cin = vc[i];
            @(posedge clk); #1;
            compared++;
            if (S !== vs[i] || Cout !== vco[i] || out_valid !== 1'b1) begin
                mismatched++;
                $display("FAIL b2b%0d: S=%h Cout=%b ov=%b required %h/%b/1", i, S, Cout, out_valid, vs[i], vco[i]);
            end
`ifdef ADDER_8B_FLAGS_EN
            compared++;
            if (Ovf !== vovf[i] || Zero !== vz[i]) begin
                mismatched++;
                $display("FAIL b2b_flags%0d: Ovf=%b Zero=%b required %b/%b", i, Ovf, Zero, vovf[i], vz[i]);
            end
`endif
        end
    endtask

    task automatic test_reset_midstream;
        @(negedge clk);
        in_valid = 1'b1; A = va[2]; B = vb[2]; Cin = vc[2];
        @(posedge clk); #1;
        #2 rst_n = 1'b0;
        #1;
        compared++;
        if (S !== 8'h00 || Cout !== 1'b0 || out_valid !== 1'b0) begin
            mismatched++;
            $display("FAIL mid_reset: S=%h Cout=%b ov=%b required 00/0/0", S, Cout, out_valid);
        end
        @(posedge clk); #1;
        compared++;
        if (S !== 8'h00 || Cout !== 1'b0 || out_valid !== 1'b0) begin
            mismatched++;
            $display("FAIL mid_reset_held: S=%h Cout=%b ov=%b required 00/0/0", S, Cout, out_valid);
        end
        @(negedge clk); rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            A = va[i]; B = vb[i]; Cin = vc[i];
            @(posedge clk); #1;
            compared++;
            if (S !== vs[i] || Cout !== vco[i] || out_valid !== 1'b1) begin
                mismatched++;
                $display("FAIL resume%0d: S=%h Cout=%b ov=%b required %h/%b/1", i, S, Cout, out_valid, vs[i], vco[i]);
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        @(posedge clk); #1;
        compared++;
        if (out_valid !== 1'b0 || S !== vs[3]) begin
            mismatched++;
            $display("FAIL resume_drop: S=%h ov=%b required %h/0", S, out_valid, vs[3]);
        end
    endtask

    initial begin
        compared = 0; mismatched = 0;
        rst_n = 1'b0; in_valid = 1'b0; A = 8'h00; B = 8'h00; Cin = 1'b0;
        #12 rst_n = 1'b1;
        test_reset;
        test_single;
        test_back_to_back;
        test_reset_midstream;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
